// File: rtl/router_pkg.sv
// Shared constants and types for the router packet FIFO: header length field
// position, default sizing and the read-side packet FSM state encoding.
package router_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // Holds payload length plus the trailing parity byte, so one bit wider.
  localparam int REMAIN_W = HDR_LEN_W + 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BODY = 1'b1
  } rd_state_e;

endpackage

// File: rtl/router_pkt_len_tracker.sv
// Read-side packet framing: follows header/payload/parity bytes as they leave
// the FIFO and pulses pkt_last alongside the final (parity) byte on data_out.
//
// state   | meaning
// --------+------------------------------------------------------------
// RD_IDLE | between packets; unflagged bytes pass through unframed
// RD_BODY | inside a packet; remain counts payload + parity still to go
module router_pkt_len_tracker
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 soft_reset,
  input  logic                 rd_acc,
  input  logic                 rd_hdr,
  input  logic [HDR_LEN_W-1:0] rd_len,
  output logic                 pkt_last,
  output logic                 in_packet
);

  rd_state_e           state;
  rd_state_e           state_next;
  logic [REMAIN_W-1:0] remain;
  logic                last_read;

  assign last_read = rd_acc && !rd_hdr && (state == RD_BODY) && (remain == REMAIN_W'(1));

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) state <= RD_IDLE;
    else                       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE: if (rd_acc && rd_hdr) state_next = RD_BODY;
      RD_BODY: begin
        // A new header mid-packet abandons the old one and stays in BODY.
        if (rd_acc && rd_hdr) state_next = RD_BODY;
        else if (last_read)   state_next = RD_IDLE;
      end
      default: state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    in_packet = (state == RD_BODY);
  end

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      remain   <= '0;
      pkt_last <= 1'b0;
    end else begin
      pkt_last <= last_read;
      if (rd_acc && rd_hdr)
        remain <= REMAIN_W'(rd_len) + REMAIN_W'(1);
      else if (rd_acc && (state == RD_BODY))
        remain <= remain - REMAIN_W'(1);
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Router output-port FIFO: stores bytes tagged with a header flag, registered
// read data, occupancy flags, and packet framing via the length tracker.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       soft_reset,
  input  logic                       write_enb,
  input  logic                       lfd_state,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       read_enb,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       pkt_last,
  output logic                       in_packet
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W:0]   rd_entry;
  logic              rd_acc;
  logic              wr_acc;
  logic              flush;

  assign flush    = !resetn || soft_reset;
  assign rd_acc   = read_enb && !empty;
  // A full FIFO still takes a write when a read frees a slot the same cycle.
  assign wr_acc   = write_enb && (!full || rd_acc);
  assign rd_entry = mem[rd_ptr];

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));

  always_ff @(posedge clock) begin
    if (!flush && wr_acc) mem[wr_ptr] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= rd_entry[DATA_W-1:0];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  router_pkt_len_tracker u_len_tracker (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .rd_acc     (rd_acc),
    .rd_hdr     (rd_entry[DATA_W]),
    .rd_len     (rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]),
    .pkt_last   (pkt_last),
    .in_packet  (in_packet)
  );

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: default 8x16 instance plus a 12x32 instance.
module tb_router_pkt_fifo;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, pkt_last, in_packet;
  logic [4:0] count;

  logic        w_soft_reset, w_write_enb, w_lfd_state, w_read_enb;
  logic [11:0] w_data_in, w_data_out;
  logic        w_full, w_empty, w_almost_full, w_pkt_last, w_in_packet;
  logic [5:0]  w_count;

  int checks = 0;
  int errors = 0;

  logic [8:0]  sb [$];
  int          mcount = 0;
  logic [12:0] sbw [$];
  int          mcw = 0;

  router_pkt_fifo dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .pkt_last(pkt_last),
    .in_packet(in_packet)
  );

  router_pkt_fifo #(.DATA_W(12), .DEPTH(32)) dut_w (
    .clock(clock), .resetn(resetn), .soft_reset(w_soft_reset),
    .write_enb(w_write_enb), .lfd_state(w_lfd_state), .data_in(w_data_in),
    .read_enb(w_read_enb), .data_out(w_data_out), .full(w_full), .empty(w_empty),
    .almost_full(w_almost_full), .count(w_count), .pkt_last(w_pkt_last),
    .in_packet(w_in_packet)
  );

  // One clock of stimulus on the default instance with scoreboard checking.
  task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                      input logic re, input logic sr);
    logic       rd_ok, wr_ok;
    logic [8:0] exp;
    exp   = '0;
    rd_ok = re && (mcount > 0) && !sr;
    wr_ok = we && ((mcount < 16) || rd_ok) && !sr;
    if (rd_ok) exp = sb.pop_front();
    if (wr_ok) sb.push_back({lfd, din});
    if (sr) begin
      sb.delete();
      mcount = 0;
    end else begin
      mcount = mcount + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    end
    write_enb = we; lfd_state = lfd; data_in = din; read_enb = re; soft_reset = sr;
    @(posedge clock); #1;
    write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0; soft_reset = 0;
    checks++;
    if (count !== 5'(mcount)) begin
      errors++;
      $display("FAIL count: got %0d expected %0d", count, mcount);
    end
    if (rd_ok) begin
      checks++;
      if (data_out !== exp[7:0]) begin
        errors++;
        $display("FAIL data_out: got %h expected %h", data_out, exp[7:0]);
      end
    end
    if (sr) begin
      checks++;
      if (data_out !== 8'h00 || empty !== 1'b1 || in_packet !== 1'b0 || pkt_last !== 1'b0) begin
        errors++;
        $display("FAIL soft_reset_state: data_out=%h empty=%b in_packet=%b pkt_last=%b expected 00 1 0 0",
                 data_out, empty, in_packet, pkt_last);
      end
    end
  endtask

  task automatic step_w(input logic we, input logic [11:0] din, input logic re);
    logic        rd_ok, wr_ok;
    logic [12:0] exp;
    exp   = '0;
    rd_ok = re && (mcw > 0);
    wr_ok = we && ((mcw < 32) || rd_ok);
    if (rd_ok) exp = sbw.pop_front();
    if (wr_ok) sbw.push_back({1'b0, din});
    mcw = mcw + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    w_write_enb = we; w_data_in = din; w_read_enb = re;
    @(posedge clock); #1;
    w_write_enb = 0; w_data_in = '0; w_read_enb = 0;
    checks++;
    if (w_count !== 6'(mcw)) begin
      errors++;
      $display("FAIL w_count: got %0d expected %0d", w_count, mcw);
    end
    if (rd_ok) begin
      checks++;
      if (w_data_out !== exp[11:0]) begin
        errors++;
        $display("FAIL w_data_out: got %h expected %h", w_data_out, exp[11:0]);
      end
    end
  endtask

  task automatic check_frame(input string name, input logic exp_inp, input logic exp_last);
    checks++;
    if (in_packet !== exp_inp || pkt_last !== exp_last) begin
      errors++;
      $display("FAIL %s: in_packet=%b pkt_last=%b expected %b %b",
               name, in_packet, pkt_last, exp_inp, exp_last);
    end
  endtask

  task automatic test_reset();
    resetn = 0; write_enb = 1; read_enb = 1; data_in = 8'hEE;
    @(posedge clock); #1;
    resetn = 1; write_enb = 0; read_enb = 0; data_in = '0;
    sb.delete(); mcount = 0; sbw.delete(); mcw = 0;
    checks++;
    if (empty !== 1 || full !== 0 || almost_full !== 0 || in_packet !== 0 ||
        count !== 5'd0 || data_out !== 8'h00 || pkt_last !== 0) begin
      errors++;
      $display("FAIL reset: empty=%b full=%b af=%b inp=%b count=%0d dout=%h last=%b expected 1 0 0 0 0 00 0",
               empty, full, almost_full, in_packet, count, data_out, pkt_last);
    end
    checks++;
    if (w_empty !== 1 || w_count !== 6'd0 || w_data_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_wide: empty=%b count=%0d dout=%h expected 1 0 000", w_empty, w_count, w_data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 17; i++) begin
      step(1, 0, 8'(i * 7 + 3), 0, 0);
      checks++;
      if (almost_full !== (mcount >= 14) || full !== (mcount == 16) || empty !== 0) begin
        errors++;
        $display("FAIL fill_flags[%0d]: af=%b full=%b empty=%b expected %b %b 0",
                 i, almost_full, full, empty, mcount >= 14, mcount == 16);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'(8'hA0 + i), 1, 0);
      checks++;
      if (full !== 1) begin
        errors++;
        $display("FAIL b2b_full[%0d]: got %b expected 1", i, full);
      end
    end
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1, 0);
    checks++;
    if (empty !== 1 || almost_full !== 0) begin
      errors++;
      $display("FAIL drain_flags: empty=%b af=%b expected 1 0", empty, almost_full);
    end
    step(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_packet();
    logic [7:0] bytes [5];
    bytes = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'hAA};
    for (int i = 0; i < 5; i++) step(1, i == 0, bytes[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 1, 0);
      check_frame($sformatf("pkt3_read%0d", i + 1), i < 4, i == 4);
    end
    step(0, 0, 8'h00, 0, 0);
    check_frame("pkt3_after", 0, 0);
  endtask

  task automatic test_zero_len();
    step(1, 1, 8'h00, 0, 0);
    step(1, 0, 8'h55, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    check_frame("len0_hdr", 1, 0);
    step(0, 0, 8'h00, 1, 0);
    check_frame("len0_parity", 0, 1);
    checks++;
    if (data_out !== 8'h55) begin
      errors++;
      $display("FAIL len0_data: got %h expected 55", data_out);
    end
  endtask

  task automatic test_abandon_and_raw();
    step(1, 1, 8'h0C, 0, 0);
    step(1, 0, 8'h01, 0, 0);
    step(1, 1, 8'h04, 0, 0);
    step(1, 0, 8'h02, 0, 0);
    step(1, 0, 8'h99, 0, 0);
    step(1, 0, 8'h77, 0, 0);
    step(0, 0, 8'h00, 1, 0); check_frame("abn_hdr1", 1, 0);
    step(0, 0, 8'h00, 1, 0); check_frame("abn_pay1", 1, 0);
    step(0, 0, 8'h00, 1, 0); check_frame("abn_hdr2", 1, 0);
    step(0, 0, 8'h00, 1, 0); check_frame("abn_pay2", 1, 0);
    step(0, 0, 8'h00, 1, 0); check_frame("abn_parity", 0, 1);
    step(0, 0, 8'h00, 1, 0); check_frame("raw_idle", 0, 0);
  endtask

  task automatic test_soft_reset();
    step(1, 1, 8'h0C, 0, 0);
    step(1, 0, 8'h21, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    check_frame("sr_before", 1, 0);
    step(1, 0, 8'hBB, 1, 1);
    step(0, 0, 8'h00, 1, 0);
    step(1, 0, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    check_frame("sr_after_raw", 0, 0);
    checks++;
    if (empty !== 1) begin
      errors++;
      $display("FAIL sr_empty_after: got %b expected 1", empty);
    end
  endtask

  task automatic test_reset_mid_packet();
    step(1, 1, 8'h08, 0, 0);
    step(1, 0, 8'h41, 0, 0);
    step(1, 0, 8'h42, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    check_frame("rst_mid_before", 1, 0);
    soft_reset = 1;
    test_reset();
    soft_reset = 0;
    check_frame("rst_mid_after", 0, 0);
  endtask

  task automatic test_wide();
    for (int i = 1; i <= 33; i++) begin
      step_w(1, 12'(12'hA00 + i), 0);
      checks++;
      if (w_almost_full !== (mcw >= 30) || w_full !== (mcw == 32)) begin
        errors++;
        $display("FAIL w_fill_flags[%0d]: af=%b full=%b expected %b %b",
                 i, w_almost_full, w_full, mcw >= 30, mcw == 32);
      end
    end
    for (int i = 0; i < 5; i++) step_w(1, 12'(12'hB00 + i), 1);
    for (int i = 0; i < 32; i++) step_w(0, 12'h000, 1);
    checks++;
    if (w_empty !== 1 || w_almost_full !== 0 || w_full !== 0) begin
      errors++;
      $display("FAIL w_drain_flags: empty=%b af=%b full=%b expected 1 0 0", w_empty, w_almost_full, w_full);
    end
  endtask

  initial begin
    resetn = 1; soft_reset = 0; write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0;
    w_soft_reset = 0; w_write_enb = 0; w_lfd_state = 0; w_data_in = '0; w_read_enb = 0;
    @(posedge clock); #1;
    test_reset();
    test_fill();
    test_back_to_back();
    test_packet();
    test_zero_len();
    test_abandon_and_raw();
    test_soft_reset();
    test_reset_mid_packet();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
